prince_mprime_share_serial: RTL and testbench

//  Share-serial PRINCE M' linear-layer engine for the masked PRINCE datapath. Accepts all SHARES
//  64-bit shares of a state in one handshake and applies M' to one share per cycle using a single
//  M' instance. Shares never meet in combinational logic. Returns all shares in one handshake.

---
 rtl/prince_mprime_share_serial.sv | 126 ++++++++++++
 tb/tb_prince_mprime_share_serial.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_mprime_share_serial.sv
// rtl/prince_mprime_share_serial.sv - share-serial PRINCE M' linear layer for masked states
// Optional build macro MPRIME_SR_INV_EN appends the SR^-1 nibble permutation to each share.
module prince_mprime_share_serial #(
  parameter int SHARES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*SHARES-1:0]  in_shares,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*SHARES-1:0]  out_shares,
  output logic                  busy
);

  localparam int CW = (SHARES > 1) ? $clog2(SHARES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt;
  logic [SHARES-1:0][63:0] in_buf;
  logic [SHARES-1:0][63:0] res_buf;
  logic                    accept;
  logic                    last;
  logic                    out_fire;

  // Each output bit is the column parity of its 4-bit group minus the one excluded nibble m.
  function automatic logic [63:0] mprime(input logic [63:0] x);
    logic [63:0] y;
    int          c;
    int          m;
    y = '0;
    for (int k = 0; k < 4; k++) begin
      c = (k == 0 || k == 3) ? 3 : 0;
      for (int r = 0; r < 4; r++) begin
        for (int b = 0; b < 4; b++) begin
          m = (b - r + c + 4) % 4;
          for (int n = 0; n < 4; n++) begin
            if (n != m) y[16*k+4*r+b] = y[16*k+4*r+b] ^ x[16*k+4*n+b];
          end
        end
      end
    end
    return y;
  endfunction

`ifdef MPRIME_SR_INV_EN
  localparam int INV [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  function automatic logic [63:0] sr_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = x[4*INV[j] +: 4];
    return y;
  endfunction

  function automatic logic [63:0] share_fn(input logic [63:0] x);
    return sr_inv(mprime(x));
  endfunction
`else
  function automatic logic [63:0] share_fn(input logic [63:0] x);
    return mprime(x);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    out_fire  = 1'b0;
    last      = (cnt == CW'(SHARES - 1));
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Consumed input shares are wiped as they are transformed so no share lingers in the engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      in_buf  <= '0;
      res_buf <= '0;
    end else begin
      if (accept) begin
        in_buf <= in_shares;
        cnt    <= '0;
      end
      if (state_q == BUSY) begin
        res_buf[cnt] <= share_fn(in_buf[cnt]);
        in_buf[cnt]  <= '0;
        cnt          <= last ? '0 : cnt + CW'(1);
      end
      if (out_fire) res_buf <= '0;
    end
  end

  assign out_shares = out_valid ? res_buf : '0;

endmodule

// File: tb/tb_prince_mprime_share_serial.sv
// tb/tb_prince_mprime_share_serial.sv - self-checking bench for prince_mprime_share_serial
// Honours MPRIME_SR_INV_EN the same way as the design.
module tb_prince_mprime_share_serial;

  localparam int S = 4;
  localparam int W = 64 * S;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_shares;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_shares;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  int inv_tbl [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  typedef struct {
    string        name;
    logic [W-1:0] ins;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  prince_mprime_share_serial #(.SHARES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_shares  (in_shares),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: output bit = full column parity XOR the excluded bit in nibble m.
  function automatic logic [63:0] ref_share(input logic [63:0] x);
    logic [63:0] y;
    logic [63:0] z;
    int          m;
    y = '0;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < 4; b++) begin
          m = (b + 4 - r + ((k % 3 == 0) ? 3 : 0)) % 4;
          y[16*k+4*r+b] = x[16*k+b] ^ x[16*k+4+b] ^ x[16*k+8+b] ^ x[16*k+12+b] ^ x[16*k+4*m+b];
        end
`ifdef MPRIME_SR_INV_EN
    for (int j = 0; j < 16; j++) z[4*j +: 4] = y[4*inv_tbl[j] +: 4];
`else
    z = y;
`endif
    return z;
  endfunction

  function automatic logic [W-1:0] ref_state(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int s = 0; s < S; s++) y[64*s +: 64] = ref_share(x[64*s +: 64]);
    return y;
  endfunction

  function automatic logic [63:0] xor_shares(input logic [W-1:0] x);
    logic [63:0] a;
    a = '0;
    for (int s = 0; s < S; s++) a = a ^ x[64*s +: 64];
    return a;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: returns outputs, edges from accept to out_valid, busy cycles seen.
  task automatic run_state(input logic [W-1:0] ins, input int hold,
                           output logic [W-1:0] outs, output int lat, output int bcnt);
    bit seen;
    @(negedge clk);
    in_shares = ins;
    in_valid  = 1'b1;
    lat  = 0;
    bcnt = 0;
    seen = 0;
    outs = '0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout waiting for out_valid");
    end
    for (int i = 0; i < hold; i++) @(posedge clk);
    #1;
    outs = out_shares;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [W-1:0] outs;
  logic [W-1:0] ins;
  logic [W-1:0] exp_out;
  int           lat;
  int           bcnt;
  bit           seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_shares = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle in_ready", W'(in_ready), W'(1));
      check("idle out_valid", W'(out_valid), W'(0));
      check("idle busy", W'(busy), W'(0));
      check("idle out_shares", out_shares, '0);
    end

    vecs.push_back('{"zero", W'(0), W'(0)});
`ifdef MPRIME_SR_INV_EN
    vecs.push_back('{"unit0", W'(64'h1), W'(64'h0000_0100_0010_0001)});
    vecs.push_back('{"bit16", W'(64'h0000_0000_0001_0000), W'(64'h0100_0010_0000_1000)});
    vecs.push_back('{"unit2", W'(64'h1) << 128, W'(64'h0000_0100_0010_0001) << 128});
`else
    vecs.push_back('{"unit0", W'(64'h1), W'(64'h0000_0000_0000_0111)});
    vecs.push_back('{"bit16", W'(64'h0000_0000_0001_0000), W'(64'h0000_0000_1110_0000)});
    vecs.push_back('{"invol", W'(64'h0000_0000_1110_0000), W'(64'h0000_0000_0001_0000)});
    vecs.push_back('{"unit2", W'(64'h1) << 128, W'(64'h0000_0000_0000_0111) << 128});
`endif
    foreach (vecs[i]) begin
      run_state(vecs[i].ins, 0, outs, lat, bcnt);
      check({"vec ", vecs[i].name}, outs, vecs[i].exp);
      check({"lat ", vecs[i].name}, W'(lat), W'(S + 1));
      check({"busy ", vecs[i].name}, W'(bcnt), W'(S));
    end

    for (int t = 0; t < 1000; t++) begin
      for (int s = 0; s < S; s++) ins[64*s +: 64] = {$urandom, $urandom};
      run_state(ins, int'($urandom_range(0, 2)), outs, lat, bcnt);
      check("rand shares", outs, ref_state(ins));
      check("rand xor", W'(xor_shares(outs)), W'(ref_share(xor_shares(ins))));
      check("rand busy", W'(bcnt), W'(S));
    end

    // Stall in DONE while spurious in_valid pulses arrive.
    for (int s = 0; s < S; s++) ins[64*s +: 64] = {$urandom, $urandom};
    exp_out = ref_state(ins);
    @(negedge clk);
    in_shares = ins;
    in_valid  = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_valid) seen = 1;
    end
    check("stall reached done", W'(seen), W'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_shares = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check("stall data", out_shares, exp_out);
      check("stall valid", W'(out_valid), W'(1));
      check("stall in_ready", W'(in_ready), W'(0));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release valid", W'(out_valid), W'(0));
    check("release in_ready", W'(in_ready), W'(1));
    check("release data", out_shares, '0);
    @(posedge clk);
    #1;
    check("no ghost accept", W'(busy), W'(0));

    // Reset while BUSY with cnt=2.
    @(negedge clk);
    in_shares = {64'h4, 64'h3, 64'h2, 64'h1};
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort busy before rst", W'(busy), W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort in_ready", W'(in_ready), W'(1));
    check("abort busy", W'(busy), W'(0));
    check("abort out_valid", W'(out_valid), W'(0));
    check("abort out_shares", out_shares, '0);
    check("abort in_buf", W'(dut.in_buf), '0);
    check("abort res_buf", W'(dut.res_buf), '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort no output", W'(seen), W'(0));
    ins = {64'h0123_4567_89ab_cdef, 64'hdead_beef_0000_ffff, 64'h8000_0000_0000_0001, 64'hffff_ffff_ffff_ffff};
    run_state(ins, 1, outs, lat, bcnt);
    check("after abort data", outs, ref_state(ins));
    check("after abort lat", W'(lat), W'(S + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
